// File: rtl/divisor_iterativo_e.sv
// rtl/divisor_iterativo_e.sv - multi-cycle radix-2 restoring divider for UDIV/SDIV in execute
// Works on magnitudes, then fixes signs in a single FIX cycle before the one-cycle DONE pulse.
module divisor_iterativo_e #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic             stall_e,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] abs_a, abs_b;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         neg_q_q     <= neg_q_d;
         neg_r_q     <= neg_r_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      neg_q_d     = neg_q_q;
      neg_r_d     = neg_r_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      abs_a   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
      abs_b   = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
      // One extra bit keeps the trial subtract exact for divisors above 2^(WIDTH-1).
      shifted = {acc_q, quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_q};

      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               if (divisor == '0) begin
                  state_d     = S_DONE;
                  quotient_d  = '0;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = S_RUN;
                  cnt_d   = CNT_W'(WIDTH - 1);
                  acc_d   = '0;
                  quo_d   = abs_a;
                  dvs_d   = abs_b;
                  neg_q_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  neg_r_d = is_signed & dividend[WIDTH-1];
               end
            end
         end
         S_RUN: begin
            if (!trial[WIDTH]) begin
               acc_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = shifted[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_FIX: begin
            quotient_d  = neg_q_q ? -quo_q : quo_q;
            remainder_d = neg_r_q ? -acc_q : acc_q;
            dbz_d       = 1'b0;
            state_d     = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      // Flush abandons the operation but leaves the previously published result intact.
      if (flush) begin
         state_d     = S_IDLE;
         quotient_d  = quotient_q;
         remainder_d = remainder_q;
         dbz_d       = dbz_q;
      end
   end

   assign stall_e     = ((state_q == S_IDLE) && start) || (state_q == S_RUN) || (state_q == S_FIX);
   assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
   assign done        = (state_q == S_DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule
